timer_counter: RTL and testbench

- Timer/counter core fed by the external clock prescaler stage. It consumes that stage's single-pclk-cycle count pulse (clk_pulse).
- Provides a loadable up/down counter with auto-reload, one-shot mode, overflow/underflow/compare flags and a maskable interrupt.
- All logic runs in the pclk domain.

---
 rtl/timer_counter.sv | 131 +++++++++++++
 tb/tb_timer_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Timer/counter core driven by the prescaler's single-cycle count pulse.
// It provides a loadable up/down counter with auto-reload, a one-shot
// mode, sticky overflow/underflow/compare flags and a maskable interrupt.
// Everything runs in the pclk domain.

module timer_counter #(
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             clk_pulse,
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic [2:0]       irq_en,
    input  logic [2:0]       flag_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf,
    output logic             udf,
    output logic             cmp_match,
    output logic             irq,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rld;
    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic             wrap;
    logic             ovf_set;
    logic             udf_set;
    logic             cmp_set;
    logic [WIDTH-1:0] cnt_next;

    // Qualify the tick and compute the counter's next value and flag events
    always_comb begin
        // NOTE: every signal gets a value on every path so no latch is inferred.
        // A load on the same edge swallows the tick entirely.
        tick     = (state == RUN) && en && clk_pulse && !load;
        at_max   = (cnt == '1);
        at_zero  = (cnt == '0);
        cnt_next = cnt;
        if (dir) begin
            cnt_next = at_zero ? rld : cnt - WIDTH'(1);
        end else begin
            cnt_next = at_max ? rld : cnt + WIDTH'(1);
        end
        wrap    = tick && (dir ? at_zero : at_max);
        ovf_set = wrap && !dir;
        udf_set = wrap && dir;
        cmp_set = tick && (cnt_next == cmp_val);
    end

    // Run-control FSM; running is registered together with the state
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!presetn) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (oneshot && wrap) begin
                        state   <= DONE;
                        running <= 1'b0;
                    end
                end
                DONE: begin
                    if (!en) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Counter and reload register: load has priority over a tick
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt <= '0;
            rld <= '0;
        end else if (load) begin
            cnt <= load_val;
            rld <= load_val;
        end else if (tick) begin
            cnt <= cnt_next;
        end
    end

    // Sticky flags: a set on the same edge as its clear strobe wins
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ovf       <= 1'b0;
            udf       <= 1'b0;
            cmp_match <= 1'b0;
        end else begin
            ovf       <= ovf_set | (ovf       & ~flag_clr[0]);
            udf       <= udf_set | (udf       & ~flag_clr[1]);
            cmp_match <= cmp_set | (cmp_match & ~flag_clr[2]);
        end
    end

    // Interrupt request straight from the flag registers and their enables
    assign irq = |({cmp_match, udf, ovf} & irq_en);

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter. Expected outputs are queued when
// stimulus is driven and popped/compared once the DUT has updated.

module tb_timer_counter;

    localparam int WIDTH = 8;

    logic             pclk;
    logic             presetn;
    logic             clk_pulse;
    logic             en;
    logic             dir;
    logic             oneshot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cmp_val;
    logic [2:0]       irq_en;
    logic [2:0]       flag_clr;
    logic [WIDTH-1:0] cnt;
    logic             ovf;
    logic             udf;
    logic             cmp_match;
    logic             irq;
    logic             running;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] cnt;
        logic [2:0]       flags;   // {cmp, udf, ovf}
        logic             irq;
        logic             running;
    } exp_t;

    exp_t exp_q[$];

    timer_counter #(.WIDTH(WIDTH)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .clk_pulse (clk_pulse),
        .en        (en),
        .dir       (dir),
        .oneshot   (oneshot),
        .load      (load),
        .load_val  (load_val),
        .cmp_val   (cmp_val),
        .irq_en    (irq_en),
        .flag_clr  (flag_clr),
        .cnt       (cnt),
        .ovf       (ovf),
        .udf       (udf),
        .cmp_match (cmp_match),
        .irq       (irq),
        .running   (running)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [WIDTH-1:0] c,
                            input logic [2:0] f, input logic i, input logic r);
        exp_t e;
        e.tag     = tag;
        e.cnt     = c;
        e.flags   = f;
        e.irq     = i;
        e.running = r;
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".cnt"},     32'(cnt),                      32'(e.cnt));
            check({e.tag, ".flags"},   32'({cmp_match, udf, ovf}),    32'(e.flags));
            check({e.tag, ".irq"},     32'(irq),                      32'(e.irq));
            check({e.tag, ".running"}, 32'(running),                  32'(e.running));
        end
    endtask

    // One clock with current inputs, then compare against the queued result
    task automatic step(input string tag, input logic [WIDTH-1:0] c,
                        input logic [2:0] f, input logic i, input logic r);
        push_exp(tag, c, f, i, r);
        cyc();
        compare_out();
    endtask

    // Single count pulse, checked, followed by three idle cycles
    task automatic tick(input string tag, input logic [WIDTH-1:0] c,
                        input logic [2:0] f, input logic i, input logic r);
        clk_pulse = 1'b1;
        step(tag, c, f, i, r);
        clk_pulse = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic do_load(input string tag, input logic [WIDTH-1:0] v,
                           input logic [2:0] f, input logic i, input logic r);
        load     = 1'b1;
        load_val = v;
        step(tag, v, f, i, r);
        load = 1'b0;
    endtask

    initial begin
        presetn   = 1'b0;
        clk_pulse = 1'b1;
        en        = 1'b1;
        dir       = 1'b0;
        oneshot   = 1'b0;
        load      = 1'b1;
        load_val  = 8'hAA;
        cmp_val   = 8'h00;
        irq_en    = 3'b000;
        flag_clr  = 3'b000;

        // Reset held with en, tick and load all active
        repeat (2) cyc();
        presetn   = 1'b1;
        clk_pulse = 1'b0;
        load      = 1'b0;
        push_exp("reset", 8'h00, 3'b000, 1'b0, 1'b0);
        compare_out();
        step("run_after_reset", 8'h00, 3'b000, 1'b0, 1'b1);

        // Up count with auto-reload on overflow
        dir    = 1'b0;
        irq_en = 3'b001;
        cmp_val = 8'h80;
        do_load("up_load", 8'hFD, 3'b000, 1'b0, 1'b1);
        tick("up_t1", 8'hFE, 3'b000, 1'b0, 1'b1);
        tick("up_t2", 8'hFF, 3'b000, 1'b0, 1'b1);
        tick("up_wrap", 8'hFD, 3'b001, 1'b1, 1'b1);
        flag_clr = 3'b001;
        step("ovf_clr", 8'hFD, 3'b000, 1'b0, 1'b1);
        flag_clr = 3'b000;

        // Down count, one-shot
        dir     = 1'b1;
        oneshot = 1'b1;
        do_load("dn_load", 8'h02, 3'b000, 1'b0, 1'b1);
        tick("dn_t1", 8'h01, 3'b000, 1'b0, 1'b1);
        tick("dn_t2", 8'h00, 3'b000, 1'b0, 1'b1);
        tick("dn_wrap", 8'h02, 3'b010, 1'b0, 1'b0);
        tick("done_t1", 8'h02, 3'b010, 1'b0, 1'b0);
        tick("done_t2", 8'h02, 3'b010, 1'b0, 1'b0);
        en = 1'b0;
        step("done_en_off", 8'h02, 3'b010, 1'b0, 1'b0);
        en = 1'b1;
        step("done_en_on", 8'h02, 3'b010, 1'b0, 1'b1);
        tick("rerun_t1", 8'h01, 3'b010, 1'b0, 1'b1);
        irq_en = 3'b010;
        step("udf_irq", 8'h01, 3'b010, 1'b1, 1'b1);
        flag_clr = 3'b010;
        step("udf_clr", 8'h01, 3'b000, 1'b0, 1'b1);
        flag_clr = 3'b000;

        // Compare match, masking and set-vs-clear race
        dir     = 1'b0;
        oneshot = 1'b0;
        cmp_val = 8'h05;
        irq_en  = 3'b100;
        do_load("cmp_load", 8'h03, 3'b000, 1'b0, 1'b1);
        tick("cmp_t1", 8'h04, 3'b000, 1'b0, 1'b1);
        tick("cmp_hit", 8'h05, 3'b100, 1'b1, 1'b1);
        irq_en = 3'b000;
        step("cmp_masked", 8'h05, 3'b100, 1'b0, 1'b1);
        irq_en = 3'b100;
        do_load("cmp_reload", 8'h04, 3'b100, 1'b1, 1'b1);
        flag_clr = 3'b100;
        tick("cmp_race", 8'h05, 3'b100, 1'b1, 1'b1);
        flag_clr = 3'b100;
        step("cmp_clr", 8'h05, 3'b000, 1'b0, 1'b1);
        flag_clr = 3'b000;

        // Load colliding with a tick, then disable
        cmp_val = 8'h10;
        do_load("coll_pre", 8'h30, 3'b000, 1'b0, 1'b1);
        clk_pulse = 1'b1;
        do_load("coll_load", 8'h10, 3'b000, 1'b0, 1'b1);
        clk_pulse = 1'b0;
        en = 1'b0;
        step("disable", 8'h10, 3'b000, 1'b0, 1'b0);
        tick("off_t1", 8'h10, 3'b000, 1'b0, 1'b0);
        tick("off_t2", 8'h10, 3'b000, 1'b0, 1'b0);
        tick("off_t3", 8'h10, 3'b000, 1'b0, 1'b0);

        // Mid-count reset overrides everything
        en = 1'b1;
        step("reen", 8'h10, 3'b000, 1'b0, 1'b1);
        presetn   = 1'b0;
        clk_pulse = 1'b1;
        step("mid_reset", 8'h00, 3'b000, 1'b0, 1'b0);
        presetn   = 1'b1;
        clk_pulse = 1'b0;

        if (exp_q.size() != 0) check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
